game_input_scheduler: RTL

//  Converts decoded PS/2 key events into per-frame player commands for the slide-platform game.

---
 rtl/game_input_pkg.sv | 32 +++
 rtl/key_edge_tracker.sv | 44 ++++
 rtl/game_input_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/game_input_pkg.sv
// Shared types and constants for the game input scheduler.
package game_input_pkg;

    // Resolved horizontal direction for a frame
    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    // Default PS/2 set-2 scan codes
    localparam logic [7:0] DEF_LEFT_CODE  = 8'h6B;
    localparam logic [7:0] DEF_RIGHT_CODE = 8'h74;
    localparam logic [7:0] DEF_JUMP_CODE  = 8'h75;
    localparam logic [7:0] DEF_PAUSE_CODE = 8'h29;

    // Hold counter width; holds RAMP_TICKS up to 15
    localparam int RAMP_W = 4;

    // Key slot indices into the tracker array
    localparam int NUM_KEYS  = 4;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_JUMP  = 2;
    localparam int KEY_PAUSE = 3;

    // move_speed encodings
    localparam logic [1:0] SPD_NONE = 2'd0;
    localparam logic [1:0] SPD_SLOW = 2'd1;
    localparam logic [1:0] SPD_FAST = 2'd2;

endpackage

// File: rtl/key_edge_tracker.sv
// Per-key press state with a one-cycle press edge; typematic repeats and
// releases of an unpressed key leave the state untouched.
module key_edge_tracker #(
    parameter logic [7:0] CODE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic       makeBreak,
    input  logic [7:0] outCode,
    output logic       pressed,
    output logic       press_edge
);

    logic pressed_q, pressed_d;
    logic hit;

    assign hit = valid && (outCode == CODE);

    // Next press state and edge from the current event
    always_comb begin
        pressed_d  = pressed_q;
        press_edge = 1'b0;
        if (hit) begin
            if (makeBreak) begin
                if (!pressed_q) begin
                    pressed_d  = 1'b1;
                    press_edge = 1'b1;
                end
            end else begin
                pressed_d = 1'b0;
            end
        end
    end

    // Key state register
    always_ff @(posedge clk) begin
        if (reset) pressed_q <= 1'b0;
        else       pressed_q <= pressed_d;
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/game_input_scheduler.sv
// Turns decoded PS/2 key events into per-frame movement, jump and pause
// commands. Key state updates on every event; movement outputs only move on tick.
module game_input_scheduler
    import game_input_pkg::*;
#(
    parameter logic [7:0] LEFT_CODE  = DEF_LEFT_CODE,
    parameter logic [7:0] RIGHT_CODE = DEF_RIGHT_CODE,
    parameter logic [7:0] JUMP_CODE  = DEF_JUMP_CODE,
    parameter logic [7:0] PAUSE_CODE = DEF_PAUSE_CODE,
    parameter int         RAMP_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic       makeBreak,
    input  logic [7:0] outCode,
    input  logic       tick,
    output logic       move_left,
    output logic       move_right,
    output logic [1:0] move_speed,
    output logic       jump,
    output logic       paused
);

    localparam logic [NUM_KEYS-1:0][7:0] KEY_CODES = {PAUSE_CODE, JUMP_CODE, RIGHT_CODE, LEFT_CODE};
    localparam logic [RAMP_W-1:0]        RAMP_MAX  = RAMP_W'(RAMP_TICKS);

    logic [NUM_KEYS-1:0] pressed, press_edge;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_edge_tracker #(.CODE(KEY_CODES[k])) u_trk (
            .clk        (clk),
            .reset      (reset),
            .valid      (valid),
            .makeBreak  (makeBreak),
            .outCode    (outCode),
            .pressed    (pressed[k]),
            .press_edge (press_edge[k])
        );
    end

    // Only press edges matter for jump and pause
    logic unused_held;
    assign unused_held = ^{pressed[KEY_JUMP], pressed[KEY_PAUSE]};

    dir_t              last_dir_q, last_dir_d;
    dir_t              prev_dir_q, prev_dir_d;
    dir_t              cur_dir;
    logic [RAMP_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              jump_pend_q, jump_pend_d;
    logic              paused_q, paused_d;
    logic              move_left_q, move_left_d;
    logic              move_right_q, move_right_d;
    logic [1:0]        move_speed_q, move_speed_d;
    logic              jump_q, jump_d;

    // Direction from held keys; last press breaks a tie
    always_comb begin
        cur_dir = DIR_NONE;
        case ({pressed[KEY_RIGHT], pressed[KEY_LEFT]})
            2'b01:   cur_dir = DIR_LEFT;
            2'b10:   cur_dir = DIR_RIGHT;
            2'b11:   cur_dir = last_dir_q;
            default: cur_dir = DIR_NONE;
        endcase
    end

    // Event-driven state: last pressed direction, pause toggle, pending jump
    always_comb begin
        last_dir_d  = last_dir_q;
        paused_d    = paused_q;
        jump_pend_d = jump_pend_q;
        jump_d      = 1'b0;

        if (press_edge[KEY_LEFT])       last_dir_d = DIR_LEFT;
        else if (press_edge[KEY_RIGHT]) last_dir_d = DIR_RIGHT;

        // A tick consumes the pending jump using the pre-event state
        if (tick && jump_pend_q && !paused_q) begin
            jump_d      = 1'b1;
            jump_pend_d = 1'b0;
        end
        // Jump presses made while paused are dropped so unpausing never fires a stale jump
        if (press_edge[KEY_JUMP] && !paused_q) jump_pend_d = 1'b1;
        if (press_edge[KEY_PAUSE]) begin
            paused_d    = !paused_q;
            jump_pend_d = 1'b0;
        end
    end

    // Frame update: movement and speed ramp sampled on tick
    always_comb begin
        prev_dir_d   = prev_dir_q;
        hold_cnt_d   = hold_cnt_q;
        move_left_d  = move_left_q;
        move_right_d = move_right_q;
        move_speed_d = move_speed_q;
        if (tick) begin
            if (paused_q) begin
                prev_dir_d   = DIR_NONE;
                hold_cnt_d   = '0;
                move_left_d  = 1'b0;
                move_right_d = 1'b0;
                move_speed_d = SPD_NONE;
            end else begin
                prev_dir_d = cur_dir;
                if (cur_dir != DIR_NONE && cur_dir == prev_dir_q)
                    hold_cnt_d = (hold_cnt_q == RAMP_MAX) ? hold_cnt_q : hold_cnt_q + RAMP_W'(1);
                else
                    hold_cnt_d = '0;
                move_left_d  = (cur_dir == DIR_LEFT);
                move_right_d = (cur_dir == DIR_RIGHT);
                if (cur_dir == DIR_NONE)       move_speed_d = SPD_NONE;
                else if (hold_cnt_d == RAMP_MAX) move_speed_d = SPD_FAST;
                else                             move_speed_d = SPD_SLOW;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dir_q   <= DIR_NONE;
            prev_dir_q   <= DIR_NONE;
            hold_cnt_q   <= '0;
            jump_pend_q  <= 1'b0;
            paused_q     <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            move_speed_q <= SPD_NONE;
            jump_q       <= 1'b0;
        end else begin
            last_dir_q   <= last_dir_d;
            prev_dir_q   <= prev_dir_d;
            hold_cnt_q   <= hold_cnt_d;
            jump_pend_q  <= jump_pend_d;
            paused_q     <= paused_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            move_speed_q <= move_speed_d;
            jump_q       <= jump_d;
        end
    end

    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign move_speed = move_speed_q;
    assign jump       = jump_q;
    assign paused     = paused_q;

endmodule
